// File: rtl/oc_fault_monitor.sv
// Overcurrent qualifier/latch: 2-flop sync, glitch filter, cooldown hold, trip count, lockout; OC_STICKY_FLAG_EN adds FaultSeen.
// Latency: Over rises QUAL_CYCLES+2 edges after SenseRaw is first sampled high; all outputs registered; no backpressure.
module oc_fault_monitor #(
  parameter int QUAL_CYCLES      = 16,
  parameter int COOLDOWN_CYCLES  = 100000,
  parameter int MAX_TRIPS        = 3,
  parameter int RUN_CLEAR_CYCLES = 1000000
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             SenseRaw,
  input  logic                             ClearLockout,
  output logic                             Over,
  output logic                             Lockout,
  output logic                             Tripped,
`ifdef OC_STICKY_FLAG_EN
  output logic                             FaultSeen,
`endif
  output logic [$clog2(MAX_TRIPS+1)-1:0]   TripCount
);

  localparam int QW = $clog2(QUAL_CYCLES + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam int RW = $clog2(RUN_CLEAR_CYCLES + 1);
  localparam int TW = $clog2(MAX_TRIPS + 1);

  localparam logic [QW-1:0] QUAL_MAX = QW'(QUAL_CYCLES);
  localparam logic [CW-1:0] CD_LAST  = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] TRIP_MAX = TW'(MAX_TRIPS);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_QUAL,
    ST_COOLDOWN,
    ST_LOCKOUT
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [QW-1:0]   qual_cnt_q, qual_cnt_d;
  logic [CW-1:0]   cd_cnt_q, cd_cnt_d;
  logic [RW-1:0]   clean_cnt_q, clean_cnt_d;
  logic [TW-1:0]   trip_count_q, trip_count_d;
  logic [TW-1:0]   trip_inc;
  logic            over_q, over_d;
  logic            lockout_q, lockout_d;
  logic            tripped_q, tripped_d;
  logic            trip_evt;
  logic            sense_sync;

  assign sense_sync = sync2_q;

  always_comb begin
    state_d      = state_q;
    qual_cnt_d   = qual_cnt_q;
    cd_cnt_d     = cd_cnt_q;
    clean_cnt_d  = clean_cnt_q;
    trip_count_d = trip_count_q;
    trip_evt     = 1'b0;
    // Only reachable from QUAL, where the count is always below MAX_TRIPS.
    trip_inc     = trip_count_q + TW'(1);

    case (state_q)
      ST_RUN: begin
        if (sense_sync) begin
          state_d     = ST_QUAL;
          qual_cnt_d  = QW'(1);
          clean_cnt_d = '0;
        end else if (clean_cnt_q == RUN_LAST) begin
          trip_count_d = '0;
          clean_cnt_d  = '0;
        end else begin
          clean_cnt_d = clean_cnt_q + RW'(1);
        end
      end
      ST_QUAL: begin
        if (!sense_sync) begin
          state_d     = ST_RUN;
          qual_cnt_d  = '0;
          clean_cnt_d = '0;
        end else if (qual_cnt_q == QUAL_MAX) begin
          trip_evt     = 1'b1;
          qual_cnt_d   = '0;
          trip_count_d = trip_inc;
          cd_cnt_d     = '0;
          state_d      = (trip_inc == TRIP_MAX) ? ST_LOCKOUT : ST_COOLDOWN;
        end else begin
          qual_cnt_d = qual_cnt_q + QW'(1);
        end
      end
      ST_COOLDOWN: begin
        // Sense still high at expiry simply re-arms the hold; it is not a new trip.
        if (cd_cnt_q == CD_LAST) begin
          cd_cnt_d = '0;
          if (!sense_sync) begin
            state_d     = ST_RUN;
            clean_cnt_d = '0;
          end
        end else begin
          cd_cnt_d = cd_cnt_q + CW'(1);
        end
      end
      ST_LOCKOUT: begin
        if (ClearLockout && !sense_sync) begin
          state_d      = ST_RUN;
          trip_count_d = '0;
          clean_cnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    over_d    = (state_d == ST_COOLDOWN) || (state_d == ST_LOCKOUT);
    lockout_d = (state_d == ST_LOCKOUT);
    tripped_d = trip_evt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_RUN;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      qual_cnt_q   <= '0;
      cd_cnt_q     <= '0;
      clean_cnt_q  <= '0;
      trip_count_q <= '0;
      over_q       <= 1'b0;
      lockout_q    <= 1'b0;
      tripped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= SenseRaw;
      sync2_q      <= sync1_q;
      qual_cnt_q   <= qual_cnt_d;
      cd_cnt_q     <= cd_cnt_d;
      clean_cnt_q  <= clean_cnt_d;
      trip_count_q <= trip_count_d;
      over_q       <= over_d;
      lockout_q    <= lockout_d;
      tripped_q    <= tripped_d;
    end
  end

  assign Over      = over_q;
  assign Lockout   = lockout_q;
  assign Tripped   = tripped_q;
  assign TripCount = trip_count_q;

`ifdef OC_STICKY_FLAG_EN
  logic fault_seen_q, fault_seen_d;

  always_comb begin
    fault_seen_d = fault_seen_q;
    if (trip_evt) begin
      fault_seen_d = 1'b1;
    end else if ((state_q == ST_LOCKOUT && state_d == ST_RUN) ||
                 (state_q == ST_RUN && ClearLockout)) begin
      fault_seen_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fault_seen_q <= 1'b0;
    end else begin
      fault_seen_q <= fault_seen_d;
    end
  end

  assign FaultSeen = fault_seen_q;
`endif

endmodule

// File: tb/tb_oc_fault_monitor.sv
// Directed bench for oc_fault_monitor with a timestamp-based reference model checked every cycle.
module tb_oc_fault_monitor;

  localparam int Q = 4;
  localparam int C = 10;
  localparam int M = 3;
  localparam int R = 20;

  localparam int ARMED      = 0;
  localparam int QUALIFYING = 1;
  localparam int HOLDING    = 2;
  localparam int LOCKED     = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SenseRaw = 1'b0;
  logic       ClearLockout = 1'b0;
  logic       Over;
  logic       Lockout;
  logic       Tripped;
  logic [1:0] TripCount;
`ifdef OC_STICKY_FLAG_EN
  logic       FaultSeen;
`endif

  int checks = 0;
  int errors = 0;
  int n      = 0;
  int since  = 0;
  int mode   = ARMED;
  int m_cnt  = 0;
  int pulses = 0;
  int p0     = 0;
  logic m_p1 = 1'b0;
  logic m_p2 = 1'b0;
  logic m_trip  = 1'b0;
  logic m_fault = 1'b0;

  always #5 CLK = ~CLK;

  oc_fault_monitor #(
    .QUAL_CYCLES(Q),
    .COOLDOWN_CYCLES(C),
    .MAX_TRIPS(M),
    .RUN_CLEAR_CYCLES(R)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .SenseRaw(SenseRaw),
    .ClearLockout(ClearLockout),
    .Over(Over),
    .Lockout(Lockout),
    .Tripped(Tripped),
`ifdef OC_STICKY_FLAG_EN
    .FaultSeen(FaultSeen),
`endif
    .TripCount(TripCount)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %0d expected %0d", nm, n, act, exp);
    end
  endtask

  // Reference: each phase is timed from the edge it began (since), not by counters.
  task automatic model_edge(input logic raw, input logic clr, input logic rst);
    logic ss;
    n++;
    ss = m_p2;
    m_trip = 1'b0;
    if (rst) begin
      mode = ARMED; m_cnt = 0; m_p1 = 1'b0; m_p2 = 1'b0; since = n; m_fault = 1'b0;
    end else begin
      m_p2 = m_p1;
      m_p1 = raw;
      case (mode)
        ARMED: begin
          if (clr) m_fault = 1'b0;
          if (ss) begin
            mode = QUALIFYING; since = n;
          end else if (n - since == R) begin
            m_cnt = 0; since = n;
          end
        end
        QUALIFYING: begin
          if (!ss) begin
            mode = ARMED; since = n;
          end else if (n - since == Q) begin
            m_trip = 1'b1; m_fault = 1'b1; m_cnt++; since = n;
            mode = (m_cnt == M) ? LOCKED : HOLDING;
          end
        end
        HOLDING: begin
          if (n - since == C) begin
            since = n;
            if (!ss) mode = ARMED;
          end
        end
        default: begin
          if (clr && !ss) begin
            mode = ARMED; m_cnt = 0; since = n; m_fault = 1'b0;
          end
        end
      endcase
    end
  endtask

  task automatic cyc(input logic raw, input logic clr, input logic rst);
    SenseRaw = raw;
    ClearLockout = clr;
    RST = rst;
    @(posedge CLK);
    model_edge(raw, clr, rst);
    #1;
    if (Tripped === 1'b1) pulses++;
    chk("model_over", 32'(Over), 32'(mode == HOLDING || mode == LOCKED));
    chk("model_lockout", 32'(Lockout), 32'(mode == LOCKED));
    chk("model_tripped", 32'(Tripped), 32'(m_trip));
    chk("model_tripcount", 32'(TripCount), 32'(m_cnt));
`ifdef OC_STICKY_FLAG_EN
    chk("model_faultseen", 32'(FaultSeen), 32'(m_fault));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout edge %0d: got running expected finished", n);
    $fatal(1);
  end

  initial begin
    // reset state
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("rst_over", 32'(Over), 0);
    chk("rst_lockout", 32'(Lockout), 0);
    chk("rst_tripped", 32'(Tripped), 0);
    chk("rst_count", 32'(TripCount), 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // glitch reject
    p0 = pulses;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 1'b0, 1'b0);
    chk("glitch_over", 32'(Over), 0);
    chk("glitch_pulses", 32'(pulses - p0), 0);
    chk("glitch_count", 32'(TripCount), 0);

    // single trip: edges 0..5 quiet, trip on edge 6, release on edge 16
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    chk("trip_edge5_over", 32'(Over), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("trip_edge6_over", 32'(Over), 1);
    chk("trip_edge6_pulse", 32'(Tripped), 1);
    chk("trip_edge6_count", 32'(TripCount), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("trip_pulse_width", 32'(Tripped), 0);
    repeat (8) cyc(1'b0, 1'b0, 1'b0);
    chk("hold_edge15_over", 32'(Over), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("hold_edge16_over", 32'(Over), 0);

    // cooldown extension: sense still high at edge 16 restarts the hold
    p0 = pulses;
    repeat (7) cyc(1'b1, 1'b0, 1'b0);
    chk("ext_count", 32'(TripCount), 2);
    repeat (14) cyc(1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    chk("ext_edge25_over", 32'(Over), 1);
    chk("ext_edge25_count", 32'(TripCount), 2);
    chk("ext_pulses", 32'(pulses - p0), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ext_edge26_over", 32'(Over), 0);

    // third trip locks out; clear needs ClearLockout with sense low
    repeat (7) cyc(1'b1, 1'b0, 1'b0);
    chk("lock_set", 32'(Lockout), 1);
    chk("lock_count", 32'(TripCount), 3);
    chk("lock_model_count", 32'(m_cnt), 3);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    chk("lock_clr_sense_high", 32'(Lockout), 1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    chk("lock_no_memory", 32'(Lockout), 1);
    chk("lock_no_memory_over", 32'(Over), 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("unlock_over", 32'(Over), 0);
    chk("unlock_lockout", 32'(Lockout), 0);
    chk("unlock_count", 32'(TripCount), 0);

    // trip-count decay after 20 clean RUN cycles (exit edge 16, clear edge 36)
    repeat (7) cyc(1'b1, 1'b0, 1'b0);
    chk("decay_trip_count", 32'(TripCount), 1);
    repeat (10) cyc(1'b0, 1'b0, 1'b0);
    chk("decay_released", 32'(Over), 0);
    repeat (19) cyc(1'b0, 1'b0, 1'b0);
    chk("decay_edge35_count", 32'(TripCount), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("decay_edge36_count", 32'(TripCount), 0);

    // reset during cooldown, then re-qualify from scratch
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    chk("cd_before_rst_over", 32'(Over), 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("cd_rst_over", 32'(Over), 0);
    chk("cd_rst_count", 32'(TripCount), 0);
    chk("cd_rst_tripped", 32'(Tripped), 0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    chk("cd_requal_edge5", 32'(Over), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("cd_requal_edge6", 32'(Over), 1);
    chk("cd_requal_count", 32'(TripCount), 1);
    repeat (10) cyc(1'b0, 1'b0, 1'b0);

    // reach lockout again, then reset during lockout
    repeat (7) cyc(1'b1, 1'b0, 1'b0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0);
    repeat (7) cyc(1'b1, 1'b0, 1'b0);
    chk("lk2_lockout", 32'(Lockout), 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("lk_rst_over", 32'(Over), 0);
    chk("lk_rst_lockout", 32'(Lockout), 0);
    chk("lk_rst_count", 32'(TripCount), 0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    chk("lk_requal_edge5", 32'(Over), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("lk_requal_edge6", 32'(Over), 1);
    chk("lk_requal_lockout", 32'(Lockout), 0);
    chk("lk_requal_count", 32'(TripCount), 1);

    // back to RUN, then a ClearLockout pulse in RUN
    repeat (12) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("final_over", 32'(Over), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oc_fault_monitor.md
Name: oc_fault_monitor

Overview:
- Single-channel overcurrent qualifier and fault latch.
- Takes a raw, asynchronous comparator output (motor A, motor B or battery sense) and produces the clean, held Over flag that the overcurrent stage consumes.
- Three instances sit directly upstream of the drive system's overcurrent inputs: OverA, OverB and OverBat.
- Rejects glitches, enforces a cooldown hold, counts trips, and locks out after repeated faults until software or a button clears it.

Parameters:
- QUAL_CYCLES, 16: consecutive synchronized-high cycles required to trip (min 1).
- COOLDOWN_CYCLES, 100000: cycles Over is held after a trip before re-arming (min 1).
- MAX_TRIPS, 3: trip count at which the channel enters lockout (min 1).
- RUN_CLEAR_CYCLES, 1000000: consecutive cycles in RUN that clear TripCount to 0 (min 1).

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- SenseRaw  input  1  raw comparator output; asynchronous, high = overcurrent.
- ClearLockout  input  1  synchronous request to leave lockout, level or pulse.
- Over  output  1  qualified overcurrent flag to the overcurrent stage; high = disable.
- Lockout  output  1  high while in LOCKOUT.
- Tripped  output  1  one-cycle pulse on each trip event.
- TripCount  output  $clog2(MAX_TRIPS+1)  trips since last clear; saturates at MAX_TRIPS.

Behaviour:
- Single clock CLK. Reset is synchronous and active-high on RST.
- Reset (any state, including mid-cooldown or lockout): on the next edge, state = RUN, Over = 0, Lockout = 0, Tripped = 0, TripCount = 0, both synchronizer flops = 0, all counters = 0.
- Synchronizer: two-flop chain; SenseSync is SenseRaw delayed by 2 edges. Only SenseSync is used internally.
- All outputs are registered.
- RUN:
  - Over = 0.
  - Clean counter increments each cycle; when it reaches RUN_CLEAR_CYCLES, TripCount <= 0 and the counter restarts.
  - SenseSync = 1 -> QUAL with qualification count = 1; clean counter <= 0.
- QUAL:
  - Over = 0.
  - SenseSync = 0 -> RUN; qualification count <= 0; TripCount unchanged.
  - SenseSync = 1 and count reaches QUAL_CYCLES -> trip event.
- Trip event, on the same edge:
  - Over <= 1 and Tripped <= 1 for exactly one cycle.
  - TripCount <= TripCount + 1.
  - If the new value equals MAX_TRIPS -> LOCKOUT, Lockout <= 1; else -> COOLDOWN with cooldown counter = 0.
- Trip latency: with SenseRaw held high, Over rises on the (QUAL_CYCLES+2)th edge after the first edge that samples SenseRaw high. A low on SenseSync at any point before that restarts qualification.
- COOLDOWN:
  - Over = 1 regardless of SenseSync.
  - After COOLDOWN_CYCLES cycles: SenseSync = 0 -> RUN, Over <= 0; SenseSync = 1 -> cooldown counter restarts, TripCount unchanged, Tripped not pulsed.
  - ClearLockout is ignored.
- LOCKOUT:
  - Over = 1, Lockout = 1.
  - Leaves only when ClearLockout = 1 and SenseSync = 0 on the same edge: -> RUN, Over <= 0, Lockout <= 0, TripCount <= 0.
  - ClearLockout while SenseSync = 1 is ignored and has no memory.
- TripCount never exceeds MAX_TRIPS. Counters do not wrap.
- Simultaneous events:
  - RST has priority over everything.
  - A trip on the same edge as a RUN_CLEAR_CYCLES clear cannot occur, because RUN and QUAL are exclusive.

Optional Feature:
- Macro: OC_STICKY_FLAG_EN.
- Defined:
  - Adds output FaultSeen (1 bit, reset 0).
  - Set on the same edge as any trip event.
  - Cleared only by RST, or by a successful LOCKOUT exit, or by ClearLockout = 1 while in RUN.
- Undefined: FaultSeen port and its logic are absent. All other behaviour is identical.

Test Plan:
All scenarios use QUAL_CYCLES=4, COOLDOWN_CYCLES=10, MAX_TRIPS=3, RUN_CLEAR_CYCLES=20.
- Glitch reject: SenseRaw high 3 cycles, then low -> Over stays 0, Tripped never pulses, TripCount = 0.
- Single trip: SenseRaw held high from edge 0 -> Over = 1 after edge 6, Tripped high one cycle, TripCount = 1. Drop SenseRaw; Over holds 10 cycles, then returns to 0.
- Cooldown extension: SenseRaw high through the end of cooldown -> Over stays 1 for a further 10 cycles, TripCount stays 1, no Tripped pulse.
- Lockout and clear:
  - Three trips with fewer than 20 RUN cycles between them -> third trip sets Lockout = 1, TripCount = 3, Over stays 1.
  - ClearLockout with SenseRaw high -> no change.
  - SenseRaw low plus ClearLockout -> next edge Over = 0, Lockout = 0, TripCount = 0.
- Trip-count decay: one trip, then 20 consecutive RUN cycles -> TripCount returns to 0.
- Reset mid-operation: RST for one cycle during COOLDOWN and again during LOCKOUT -> after each, all outputs = 0 on the next edge and the block re-qualifies from scratch.
